// File: rtl/video_sync_gen.sv
// Programmable video raster generator with per-frame geometry shadowing
// and realignment to an external sync toggle.
module video_sync_gen #(
    parameter int HW = 12,
    parameter int VW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [HW-1:0] h_total,
    input  logic [HW-1:0] h_act,
    input  logic [HW-1:0] h_ss,
    input  logic [HW-1:0] h_se,
    input  logic [VW-1:0] v_total,
    input  logic [VW-1:0] v_act,
    input  logic [VW-1:0] v_ss,
    input  logic [VW-1:0] v_se,
    input  logic          lock_en,
    input  logic          sync_in,
    output logic          hs,
    output logic          vs,
    output logic          hbl,
    output logic          vbl,
    output logic          de,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          frame_start,
    output logic          locked
);

    logic [HW-1:0] sh_h_total, sh_h_act, sh_h_ss, sh_h_se;
    logic [VW-1:0] sh_v_total, sh_v_act, sh_v_ss, sh_v_se;

    logic          sync_q;
    logic          pend;
    logic          sync_chg;
    logic          ev;

    logic [HW-1:0] h_last, adv_h, tgt_h, h_span, nxt_h;
    logic [VW-1:0] v_last, adv_v, tgt_v, nxt_v;
    logic          h_wrap, v_wrap, frame_wrap;
    logic          on_tgt, jump;

    logic [HW-1:0] g_h_act, g_h_ss, g_h_se;
    logic [VW-1:0] g_v_act, g_v_ss, g_v_se;
    logic          nxt_hs, nxt_vs, nxt_hbl, nxt_vbl;

    assign sync_chg = sync_in ^ sync_q;
    assign ev       = pend | sync_chg;

    always_comb begin
        // totals of 0 or 1 collapse the dimension to a single position
        h_last     = (sh_h_total <= HW'(1)) ? '0 : sh_h_total - HW'(1);
        v_last     = (sh_v_total <= VW'(1)) ? '0 : sh_v_total - VW'(1);
        h_wrap     = (hcnt == h_last);
        v_wrap     = (vcnt == v_last);
        frame_wrap = h_wrap & v_wrap;

        adv_h = h_wrap ? '0 : hcnt + HW'(1);
        adv_v = vcnt;
        if (h_wrap) begin
            adv_v = v_wrap ? '0 : vcnt + VW'(1);
        end

        h_span = sh_h_se - sh_h_ss;
        tgt_h  = sh_h_ss + (h_span >> 1);
        tgt_v  = sh_v_ss;

        on_tgt = (adv_h == tgt_h) && (adv_v == tgt_v);
        jump   = ev & lock_en & ~on_tgt;

        nxt_h = jump ? tgt_h : adv_h;
        nxt_v = jump ? tgt_v : adv_v;
    end

    // outputs use the geometry that is in force after this cycle
    always_comb begin
        g_h_act = frame_wrap ? h_act : sh_h_act;
        g_h_ss  = frame_wrap ? h_ss  : sh_h_ss;
        g_h_se  = frame_wrap ? h_se  : sh_h_se;
        g_v_act = frame_wrap ? v_act : sh_v_act;
        g_v_ss  = frame_wrap ? v_ss  : sh_v_ss;
        g_v_se  = frame_wrap ? v_se  : sh_v_se;

        nxt_hbl = (nxt_h >= g_h_act);
        nxt_vbl = (nxt_v >= g_v_act);
        nxt_hs  = (nxt_h >= g_h_ss) && (nxt_h < g_h_se);
        nxt_vs  = (nxt_v >= g_v_ss) && (nxt_v < g_v_se);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_h_total <= h_total;
            sh_h_act   <= h_act;
            sh_h_ss    <= h_ss;
            sh_h_se    <= h_se;
            sh_v_total <= v_total;
            sh_v_act   <= v_act;
            sh_v_ss    <= v_ss;
            sh_v_se    <= v_se;
        end else if (ce_pix && frame_wrap) begin
            sh_h_total <= h_total;
            sh_h_act   <= h_act;
            sh_h_ss    <= h_ss;
            sh_h_se    <= h_se;
            sh_v_total <= v_total;
            sh_v_act   <= v_act;
            sh_v_ss    <= v_ss;
            sh_v_se    <= v_se;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= sync_in;
            pend   <= 1'b0;
        end else begin
            sync_q <= sync_in;
            if (ce_pix) begin
                pend <= 1'b0;
            end else if (sync_chg) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            hbl         <= 1'b0;
            vbl         <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (ce_pix) begin
                hcnt        <= nxt_h;
                vcnt        <= nxt_v;
                hs          <= nxt_hs;
                vs          <= nxt_vs;
                hbl         <= nxt_hbl;
                vbl         <= nxt_vbl;
                de          <= ~nxt_hbl & ~nxt_vbl;
                frame_start <= (nxt_h == '0) && (nxt_v == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
        end else if (!lock_en) begin
            locked <= 1'b0;
        end else if (ce_pix && ev) begin
            locked <= on_tgt;
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen: free run, lock, pending hold,
// geometry shadowing, async reset and degenerate totals.
module tb_video_sync_gen;

    localparam int HW = 12;
    localparam int VW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce_pix;
    logic [HW-1:0] h_total, h_act, h_ss, h_se;
    logic [VW-1:0] v_total, v_act, v_ss, v_se;
    logic          lock_en;
    logic          sync_in;
    logic          hs, vs, hbl, vbl, de;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          frame_start;
    logic          locked;

    int n_tot = 0;
    int n_bad = 0;
    int de_n, fs_n, hs_n, vbl_n;

    video_sync_gen #(.HW(HW), .VW(VW)) dut (
        .clk(clk),
        .reset(reset),
        .ce_pix(ce_pix),
        .h_total(h_total),
        .h_act(h_act),
        .h_ss(h_ss),
        .h_se(h_se),
        .v_total(v_total),
        .v_act(v_act),
        .v_ss(v_ss),
        .v_se(v_se),
        .lock_en(lock_en),
        .sync_in(sync_in),
        .hs(hs),
        .vs(vs),
        .hbl(hbl),
        .vbl(vbl),
        .de(de),
        .hcnt(hcnt),
        .vcnt(vcnt),
        .frame_start(frame_start),
        .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        ce_pix  = 1'b1;
        lock_en = 1'b0;
        sync_in = 1'b0;
        h_total = 10; h_act = 6; h_ss = 7; h_se = 9;
        v_total = 5;  v_act = 3; v_ss = 3; v_se = 4;
        tick(2);
        chk("rst_hcnt", hcnt, 0);
        chk("rst_vcnt", vcnt, 0);
        chk("rst_outs", {hs, vs, hbl, vbl, de}, 0);
        chk("rst_fs_lk", {frame_start, locked}, 0);
        reset = 1'b0;

        // free run: two full frames from (0,0)
        de_n = 0; fs_n = 0; hs_n = 0; vbl_n = 0;
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            de_n  += int'(de);
            fs_n  += int'(frame_start);
            hs_n  += int'(hs);
            vbl_n += int'(vbl);
            if (k == 7) begin
                chk("fr_h7_hcnt", hcnt, 7);
                chk("fr_h7_hs", hs, 1);
                chk("fr_h7_de", de, 0);
            end
            if (k == 36) begin
                chk("fr_36_pos", {20'd0, vcnt}, 3);
                chk("fr_36_vbl", {vbl, de}, 2'b10);
            end
        end
        chk("fr_de_cnt", de_n, 36);
        chk("fr_fs_cnt", fs_n, 2);
        chk("fr_hs_cnt", hs_n, 20);
        chk("fr_vbl_cnt", vbl_n, 40);
        chk("fr_end_pos", {hcnt, vcnt}, 0);

        // lock acquisition
        lock_en = 1'b1;
        tick(2);
        chk("lk_at20", {hcnt, vcnt}, {12'd2, 12'd0});
        sync_in = ~sync_in;
        tick(1);
        chk("lk_jump_pos", {hcnt, vcnt}, {12'd8, 12'd3});
        chk("lk_jump_lk", locked, 0);
        chk("lk_jump_sync", {hs, vs, vbl}, 3'b111);
        tick(49);
        chk("lk_pre_pos", {hcnt, vcnt}, {12'd7, 12'd3});
        sync_in = ~sync_in;
        tick(1);
        chk("lk_hit_pos", {hcnt, vcnt}, {12'd8, 12'd3});
        chk("lk_hit_lk", locked, 1);

        // lock_en release and ignored toggles
        lock_en = 1'b0;
        tick(1);
        chk("len0_lk", locked, 0);
        chk("len0_pos", {hcnt, vcnt}, {12'd9, 12'd3});
        sync_in = ~sync_in;
        tick(1);
        chk("len0_nojump", {hcnt, vcnt}, {12'd0, 12'd4});
        chk("len0_lk2", locked, 0);

        // pending hold with sparse ce_pix
        lock_en = 1'b1;
        ce_pix  = 1'b0;
        tick(1);
        sync_in = ~sync_in;
        tick(1);
        chk("pd_hold", {hcnt, vcnt}, {12'd0, 12'd4});
        tick(2);
        chk("pd_hold2", {hcnt, vcnt}, {12'd0, 12'd4});
        ce_pix = 1'b1;
        tick(1);
        chk("pd_jump", {hcnt, vcnt}, {12'd8, 12'd3});
        ce_pix = 1'b0;
        sync_in = ~sync_in;
        tick(1);
        sync_in = ~sync_in;
        tick(2);
        ce_pix = 1'b1;
        tick(1);
        chk("pd_dbl_jump", {hcnt, vcnt}, {12'd8, 12'd3});
        chk("pd_dbl_lk", locked, 0);
        tick(1);
        chk("pd_dbl_once", {hcnt, vcnt}, {12'd9, 12'd3});

        // geometry shadow
        lock_en = 1'b0;
        tick(25);
        chk("gs_at41", {hcnt, vcnt}, {12'd4, 12'd1});
        h_total = 12;
        tick(6);
        chk("gs_old_len", {hcnt, vcnt}, {12'd0, 12'd2});
        tick(30);
        chk("gs_wrap", {hcnt, vcnt}, 0);
        chk("gs_wrap_fs", frame_start, 1);
        tick(11);
        chk("gs_new_len", {hcnt, vcnt}, {12'd11, 12'd0});
        tick(1);
        chk("gs_new_wrap", {hcnt, vcnt}, {12'd0, 12'd1});

        // async reset mid-frame
        tick(19);
        chk("rs_pre", {hcnt, vcnt, 11'd0, hs}, {12'd7, 12'd2, 12'd1});
        lock_en = 1'b1;
        sync_in = ~sync_in;
        reset   = 1'b1;
        h_total = 10;
        #1;
        chk("rs_async_cnt", {hcnt, vcnt}, 0);
        chk("rs_async_out", {hs, vs, hbl, vbl, de, frame_start}, 0);
        tick(1);
        sync_in = ~sync_in;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("rs_rel_pos", {hcnt, vcnt}, {12'd1, 12'd0});
        chk("rs_rel_fs_lk", {frame_start, locked}, 0);
        tick(9);
        chk("rs_len10", {hcnt, vcnt}, {12'd0, 12'd1});

        // degenerate h_total
        reset   = 1'b1;
        h_total = 0;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("h0_pos", {hcnt, vcnt}, {12'd0, 12'd3});
        chk("h0_bl", {hbl, vbl, de}, 3'b010);
        tick(2);
        chk("h0_wrap", {hcnt, vcnt, 11'd0, frame_start}, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
